// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the CPU memory stage: access-width
//               encodings, memory-stage FSM states, the write-back packet
//               and the byte-lane offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Access width encodings (2'd3 is treated as a word access)
    localparam logic [1:0] DIGIT_WORD = 2'd0;
    localparam logic [1:0] DIGIT_HALF = 2'd1;
    localparam logic [1:0] DIGIT_BYTE = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regwr;
    } wb_pkt;

    // Lane offset actually used for the access: halves are forced onto a
    // half-word boundary and words onto a word boundary, so misaligned
    // addresses are truncated rather than split across words.
    function automatic logic [1:0] eff_off(input logic [1:0] digit,
                                           input logic [1:0] off);
        logic [1:0] r;
        case (digit)
            DIGIT_BYTE: r = off;
            DIGIT_HALF: r = {off[1], 1'b0};
            default:    r = 2'd0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane steering for the memory stage.
//               Store side shifts the low-aligned write mask and data up to
//               the addressed lanes; load side shifts the read word down and
//               extracts / sign- or zero-extends the byte, half or word.
// Ports       : i_st_wea, i_st_sdata, i_st_off -> o_st_we, o_st_wdata
//               i_ld_rdata, i_ld_off, i_ld_digit, i_ld_sign -> o_ld_data
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [3:0]  i_st_wea,
    input  logic [31:0] i_st_sdata,
    input  logic [1:0]  i_st_off,
    output logic [3:0]  o_st_we,
    output logic [31:0] o_st_wdata,
    input  logic [31:0] i_ld_rdata,
    input  logic [1:0]  i_ld_off,
    input  logic [1:0]  i_ld_digit,
    input  logic        i_ld_sign,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shift;

    assign o_st_we    = i_st_wea << i_st_off;
    assign o_st_wdata = i_st_sdata << {i_st_off, 3'b000};
    assign w_ld_shift = i_ld_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = w_ld_shift;
        case (i_ld_digit)
            DIGIT_BYTE: o_ld_data = {{24{i_ld_sign & w_ld_shift[7]}},  w_ld_shift[7:0]};
            DIGIT_HALF: o_ld_data = {{16{i_ld_sign & w_ld_shift[15]}}, w_ld_shift[15:0]};
            default:    o_ld_data = w_ld_shift;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline memory stage. Accepts one EX result per cycle when
//               idle, issues req/ack accesses to a single-ported data memory
//               for loads/stores (stalling upstream meanwhile), and emits a
//               one-cycle write-back packet per instruction.
// Ports       : clk, rst_n (async active-low)
//               in_*   : EX-stage instruction fields
//               stall  : upstream hold (decoded from state)
//               mem_*  : data memory request / response
//               wb_*   : write-back packet, misalign_exc : trap pulse
// Config      : `MISALIGN_TRAP_EN - trap misaligned half/word accesses
//               instead of truncating the low address bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic [3:0]        in_wea,
    input  logic              in_memrd,
    input  logic [1:0]        in_digit,
    input  logic              in_sign,
    input  logic [4:0]        in_rd,
    input  logic              in_regwr,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_regwr,
    output logic              misalign_exc
);

    state_t      r_state;
    wb_pkt       r_wb;       // packet presented on wb_* outputs
    wb_pkt       r_pend;     // captured alu/rd/regwr of the outstanding access
    logic        r_is_load;
    logic [1:0]  r_ld_off;
    logic [1:0]  r_ld_digit;
    logic        r_ld_sign;

    logic        w_is_store;
    logic        w_is_mem;
    logic        w_misalign;
    logic [1:0]  w_st_off;
    logic [3:0]  w_st_we;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;

    // A store mask wins over a simultaneous load flag
    assign w_is_store = (in_wea != 4'b0000);
    assign w_is_mem   = w_is_store | in_memrd;
    assign w_st_off   = eff_off(in_digit, in_alu[1:0]);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = w_is_mem &&
                        (((in_digit == DIGIT_HALF) && in_alu[0]) ||
                         (((in_digit == DIGIT_WORD) || (in_digit == 2'd3)) &&
                          (in_alu[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    mem_lane_align u_align (
        .i_st_wea   (in_wea),
        .i_st_sdata (in_sdata),
        .i_st_off   (w_st_off),
        .o_st_we    (w_st_we),
        .o_st_wdata (w_st_wdata),
        .i_ld_rdata (mem_rdata),
        .i_ld_off   (r_ld_off),
        .i_ld_digit (r_ld_digit),
        .i_ld_sign  (r_ld_sign),
        .o_ld_data  (w_ld_data)
    );

    assign stall    = (r_state == ST_REQ);
    assign wb_data  = r_wb.data;
    assign wb_rd    = r_wb.rd;
    assign wb_regwr = r_wb.regwr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_wb         <= '0;
            r_pend       <= '0;
            r_is_load    <= 1'b0;
            r_ld_off     <= 2'd0;
            r_ld_digit   <= 2'd0;
            r_ld_sign    <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= 4'b0000;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_exc <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (!w_is_mem) begin
                            wb_valid <= 1'b1;
                            r_wb     <= '{data: in_alu, rd: in_rd, regwr: in_regwr};
                        end else if (w_misalign) begin
                            wb_valid     <= 1'b1;
                            misalign_exc <= 1'b1;
                            r_wb         <= '{data: in_alu, rd: in_rd, regwr: 1'b0};
                        end else begin
                            r_state    <= ST_REQ;
                            mem_req    <= 1'b1;
                            mem_addr   <= in_alu[ADDR_W-1:2];
                            mem_we     <= w_is_store ? w_st_we : 4'b0000;
                            mem_wdata  <= w_st_wdata;
                            r_pend     <= '{data: in_alu, rd: in_rd, regwr: in_regwr};
                            r_is_load  <= ~w_is_store;
                            r_ld_off   <= w_st_off;
                            r_ld_digit <= in_digit;
                            r_ld_sign  <= in_sign;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_state  <= ST_IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 4'b0000;
                        wb_valid <= 1'b1;
                        r_wb     <= '{data:  r_is_load ? w_ld_data : r_pend.data,
                                      rd:    r_pend.rd,
                                      regwr: r_is_load & r_pend.regwr};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_alu;
    logic [31:0] in_sdata;
    logic [3:0]  in_wea;
    logic        in_memrd;
    logic [1:0]  in_digit;
    logic        in_sign;
    logic [4:0]  in_rd;
    logic        in_regwr;
    logic        stall;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_regwr;
    logic        misalign_exc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_alu       (in_alu),
        .in_sdata     (in_sdata),
        .in_wea       (in_wea),
        .in_memrd     (in_memrd),
        .in_digit     (in_digit),
        .in_sign      (in_sign),
        .in_rd        (in_rd),
        .in_regwr     (in_regwr),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_regwr     (wb_regwr),
        .misalign_exc (misalign_exc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] alu, input logic [31:0] sdata,
                           input logic [3:0] wea, input logic memrd,
                           input logic [1:0] digit, input logic sign,
                           input logic [4:0] rd, input logic regwr);
        in_valid = 1'b1;
        in_alu   = alu;
        in_sdata = sdata;
        in_wea   = wea;
        in_memrd = memrd;
        in_digit = digit;
        in_sign  = sign;
        in_rd    = rd;
        in_regwr = regwr;
    endtask

    // Garbage on the inputs while the stage is busy must not disturb it
    task automatic scramble();
        in_valid = 1'b1;
        in_alu   = 32'hFFFF_FFFC;
        in_sdata = 32'h5555_5555;
        in_wea   = 4'b1111;
        in_memrd = 1'b0;
        in_digit = 2'd0;
        in_rd    = 5'd31;
        in_regwr = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_alu    = '0;
        in_sdata  = '0;
        in_wea    = '0;
        in_memrd  = 1'b0;
        in_digit  = 2'd0;
        in_sign   = 1'b0;
        in_rd     = '0;
        in_regwr  = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // ---- reset state
        #3;
        chk("rst_stall",    {31'b0, stall}, 32'd0);
        chk("rst_mem_req",  {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", {2'b0, mem_addr}, 32'd0);
        chk("rst_mem_we",   {28'b0, mem_we}, 32'd0);
        chk("rst_wdata",    mem_wdata, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_wb_data",  wb_data, 32'd0);
        chk("rst_misalign", {31'b0, misalign_exc}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // ---- non-memory op
        present(32'h1234, 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0, 5'd5, 1'b1);
        chk("nm_stall_pre", {31'b0, stall}, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("nm_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("nm_wb_data",  wb_data, 32'h1234);
        chk("nm_wb_rd",    {27'b0, wb_rd}, 32'd5);
        chk("nm_wb_regwr", {31'b0, wb_regwr}, 32'd1);
        chk("nm_stall",    {31'b0, stall}, 32'd0);
        chk("nm_mem_req",  {31'b0, mem_req}, 32'd0);
        tick();
        chk("nm_wb_pulse", {31'b0, wb_valid}, 32'd0);

        // ---- byte store at 0x103, ack after 2 wait cycles
        present(32'h103, 32'hAB, 4'b0001, 1'b0, 2'd2, 1'b0, 5'd7, 1'b1);
        tick();
        scramble();
        chk("bs_stall1",  {31'b0, stall}, 32'd1);
        chk("bs_req",     {31'b0, mem_req}, 32'd1);
        chk("bs_addr",    {2'b0, mem_addr}, 32'h40);
        chk("bs_we",      {28'b0, mem_we}, 32'b1000);
        chk("bs_wdata",   mem_wdata, 32'hAB00_0000);
        chk("bs_wbv1",    {31'b0, wb_valid}, 32'd0);
        tick();
        chk("bs_stall2",  {31'b0, stall}, 32'd1);
        chk("bs_hold_we", {28'b0, mem_we}, 32'b1000);
        chk("bs_hold_wd", mem_wdata, 32'hAB00_0000);
        tick();
        chk("bs_stall3",  {31'b0, stall}, 32'd1);
        chk("bs_hold_ad", {2'b0, mem_addr}, 32'h40);
        mem_ack = 1'b1;
        tick();
        mem_ack  = 1'b0;
        in_valid = 1'b0;
        chk("bs_stall_end", {31'b0, stall}, 32'd0);
        chk("bs_req_end",   {31'b0, mem_req}, 32'd0);
        chk("bs_wb_valid",  {31'b0, wb_valid}, 32'd1);
        chk("bs_wb_regwr",  {31'b0, wb_regwr}, 32'd0);
        chk("bs_wb_data",   wb_data, 32'h103);
        chk("bs_wb_rd",     {27'b0, wb_rd}, 32'd7);
        tick();

        // ---- signed half load at 0x202, zero-cycle ack
        present(32'h202, 32'h0, 4'b0000, 1'b1, 2'd1, 1'b1, 5'd9, 1'b1);
        tick();
        in_valid  = 1'b0;
        chk("hl_addr", {2'b0, mem_addr}, 32'h80);
        chk("hl_we",   {28'b0, mem_we}, 32'd0);
        chk("hl_req",  {31'b0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h8001_0000;
        tick();
        mem_ack = 1'b0;
        chk("hl_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("hl_wb_data_s", wb_data, 32'hFFFF_8001);
        chk("hl_wb_regwr", {31'b0, wb_regwr}, 32'd1);
        chk("hl_wb_rd",    {27'b0, wb_rd}, 32'd9);

        // ---- unsigned repeat (accepted back-to-back)
        present(32'h202, 32'h0, 4'b0000, 1'b1, 2'd1, 1'b0, 5'd9, 1'b1);
        tick();
        in_valid = 1'b0;
        mem_ack  = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("hl_wb_data_u", wb_data, 32'h0000_8001);

        // ---- signed byte load from lane 1
        present(32'h001, 32'h0, 4'b0000, 1'b1, 2'd2, 1'b1, 5'd3, 1'b1);
        tick();
        in_valid  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_F000;
        tick();
        mem_ack = 1'b0;
        chk("bl_wb_data", wb_data, 32'hFFFF_FFF0);

        // ---- half store at 0x002
        present(32'h002, 32'h1234, 4'b0011, 1'b0, 2'd1, 1'b0, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("hs_we",    {28'b0, mem_we}, 32'b1100);
        chk("hs_wdata", mem_wdata, 32'h1234_0000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("hs_wb_regwr", {31'b0, wb_regwr}, 32'd0);

        // ---- misaligned word load at 0x301
        present(32'h301, 32'h0, 4'b0000, 1'b1, 2'd0, 1'b0, 5'd6, 1'b1);
        tick();
        in_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        chk("mw_req",      {31'b0, mem_req}, 32'd0);
        chk("mw_stall",    {31'b0, stall}, 32'd0);
        chk("mw_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("mw_exc",      {31'b0, misalign_exc}, 32'd1);
        chk("mw_wb_regwr", {31'b0, wb_regwr}, 32'd0);
        tick();
        chk("mw_exc_pulse", {31'b0, misalign_exc}, 32'd0);
`else
        chk("mw_req",  {31'b0, mem_req}, 32'd1);
        chk("mw_addr", {2'b0, mem_addr}, 32'hC0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        chk("mw_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("mw_wb_data",  wb_data, 32'hDEAD_BEEF);
        chk("mw_exc",      {31'b0, misalign_exc}, 32'd0);
`endif

        // ---- reset asserted mid-access, late ack ignored
        present(32'h400, 32'h0, 4'b0000, 1'b1, 2'd0, 1'b0, 5'd8, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("ra_req_before", {31'b0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_req_async", {31'b0, mem_req}, 32'd0);
        chk("ra_stall",     {31'b0, stall}, 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        chk("ra_no_wb",  {31'b0, wb_valid}, 32'd0);
        chk("ra_no_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("ra_no_wb2", {31'b0, wb_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the pipelined CPU, directly downstream of the ID/EX control register that produces the byte write-enable mask `wea`, access width `Digit` and extension flag `Sign`. It registers one EX-stage result per accepted instruction and steers byte lanes to and from a single-ported data memory over a req/ack handshake. It sign- or zero-extends loads and forwards a register write-back packet to the WB stage. While a memory access is outstanding, it stalls the upstream pipeline.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data width; fixed at 32, with 4 byte lanes

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  an EX-stage instruction is presented
- `in_alu`  in  32  ALU result; also the byte address for memory ops
- `in_sdata`  in  32  store data, with the byte or half in the low bits
- `in_wea`  in  4  low-aligned write mask: word=1111, half=0011, byte=0001, non-store=0000
- `in_memrd`  in  1  instruction is a load
- `in_digit`  in  2  access width
- `in_sign`  in  1  1 = sign-extend a load, 0 = zero-extend
- `in_rd`  in  5  destination register
- `in_regwr`  in  1  instruction writes `in_rd`
- `stall`  out  1  upstream must hold its inputs
- `mem_req`  out  1  memory request
- `mem_addr`  out  30  word address, equal to `in_alu[31:2]`
- `mem_we`  out  4  lane-shifted byte enables; 0000 for a load
- `mem_wdata`  out  32  lane-shifted store data
- `mem_ack`  in  1  request complete; `mem_rdata` is valid in the same cycle
- `mem_rdata`  in  32  read word
- `wb_valid`  out  1  write-back packet valid; one-cycle pulse per instruction
- `wb_data`  out  32  write-back value
- `wb_rd`  out  5  write-back register
- `wb_regwr`  out  1  write enable for the register file
- `misalign_exc`  out  1  misaligned-access pulse, asserted alongside `wb_valid`

## Operation
- FSM states: IDLE, REQ.
- `stall` = (state == REQ).
- An instruction is accepted when IDLE and `in_valid` is high. The block captures all `in_*` and the lane offset `off` = `in_alu[1:0]`.
- Non-memory instruction (`in_wea` == 0 and `in_memrd` == 0):
  - stay in IDLE
  - next cycle: `wb_valid`=1, `wb_data`=`in_alu`, plus `wb_rd` and `wb_regwr`
- Store (`in_wea` != 0) or load:
  - go to REQ
  - drive `mem_req`=1
  - `mem_we` = `in_wea << off`, or 0000 for a load
  - `mem_wdata` = `in_sdata << 8*off`
  - all `mem_*` outputs are held stable until `mem_ack`
- In REQ with `mem_ack` high:
  - go to IDLE and drop `mem_req` at that edge
  - next cycle: `wb_valid`=1
  - for a load, `wb_data` = extract(`mem_rdata >> 8*off`, width), extended per `sign`
  - for a store, `wb_data` = `in_alu` and `wb_regwr` is forced to 0
- `mem_ack` is ignored while in IDLE.
- Both `in_wea` != 0 and `in_memrd` set at once is illegal; the block treats it as a store.
- Width encodings: word=2'd0, half=2'd1, byte=2'd2; 2'd3 is treated as word.

## Timing
- All outputs are registered except `stall`, which is decoded from state.
- Reset values: state IDLE, and every output 0 (`stall` 0, `mem_req` 0, `wb_valid` 0, `misalign_exc` 0, all buses 0).
- Latency:
  - non-memory instruction: 1 cycle to `wb_valid`
  - memory instruction: N+2 cycles, where N is the number of cycles spent waiting for `mem_ack` (N≥0)
- Throughput:
  - non-memory instructions: one per cycle
  - a memory op leaves IDLE unavailable from the acceptance edge until the ack edge
- Reset asserted mid-access: `mem_req` drops immediately and the transaction is abandoned. A late `mem_ack` after reset is ignored.
- `in_valid` is sampled only when IDLE. In REQ the inputs are don't-care.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - detect a half access with `off[0]`=1, or a word access with `off` != 0
  - on detection, no `mem_req` is issued
  - next cycle: `wb_valid`=1, `misalign_exc`=1, `wb_regwr`=0
- `MISALIGN_TRAP_EN` undefined:
  - `misalign_exc` is tied to 0
  - low address bits are truncated: half uses offset {`off[1]`,0}, word uses offset 0

## Structure
- Shared package `cpu_pkg`:
  - width encodings `DIGIT_WORD`, `DIGIT_HALF`, `DIGIT_BYTE`
  - FSM state enum
  - `wb_pkt` struct (data, rd, regwr)
- Sub-module `mem_lane_align` (combinational):
  - store lane shift: `wea` and data
  - load extract and extension
- The FSM and all registers live in the top module.

## Test plan
- Non-memory op: `in_alu`=0x1234, `in_rd`=5, `in_regwr`=1 → 1 cycle later `wb_valid`=1, `wb_data`=0x1234, `wb_rd`=5, `stall` never high.
- Byte store: addr 0x103, `in_sdata`=0xAB, `in_wea`=0001, ack after 2 cycles → `mem_addr`=0x40, `mem_we`=1000, `mem_wdata`=0xAB000000, `stall` high 3 cycles, `wb_regwr`=0.
- Signed half load: addr 0x202, `mem_rdata`=0x80010000, zero-cycle ack → `wb_data`=0xFFFF8001; repeat with `in_sign`=0 → 0x00008001.
- Misaligned word load at 0x301:
  - with `MISALIGN_TRAP_EN`: no `mem_req`, `misalign_exc`=1, `wb_regwr`=0
  - without it: `mem_addr`=0xC0 and the full word is returned
- Reset pulse while in REQ → `mem_req` falls asynchronously; an ack 1 cycle after reset release produces no `wb_valid`.
